// File: rtl/pipeline_stall_controller.sv
// Stall/flush/freeze sequencer for a 5-stage pipe with branches resolved in Decode.
// Latency: all enables are combinational from state + inputs; MemTimeout is registered.
// Backpressure: a memory wait freezes the whole pipe; hazards bubble ID/EX and hold PC/IF_ID.
// Optional macro STALL_PERF_CNT_EN adds saturating stall/flush/freeze performance counters.
module pipeline_stall_controller #(
  parameter int REG_W       = 5,
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [REG_W-1:0] i_ID_Rs,
  input  logic [REG_W-1:0] i_ID_Rt,
  input  logic             i_ID_UsesRs,
  input  logic             i_ID_UsesRt,
  input  logic             i_ID_Branch,
  input  logic             i_ID_BranchTaken,
  input  logic [REG_W-1:0] i_EX_Rd,
  input  logic             i_EX_RegWrite,
  input  logic             i_EX_MemRead,
  input  logic [REG_W-1:0] i_MEM_Rd,
  input  logic             i_MEM_MemRead,
  input  logic             i_MEM_Access,
  input  logic             i_MemReady,
  output logic             o_PCWrite,
  output logic             o_IF_ID_Write,
  output logic             o_IF_ID_Flush,
  output logic             o_ID_EX_Bubble,
  output logic             o_EX_MEM_Write,
  output logic             o_MEM_WB_Bubble,
  output logic             o_MemTimeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_StallCycles,
  output logic [CNT_W-1:0] o_FlushCount,
  output logic [CNT_W-1:0] o_FreezeCycles
`endif
);

  localparam int INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FREEZE, S_HALT} state_t;

  state_t            r_state;
  logic [INIT_W-1:0] r_init_cnt;
  logic [CNT_W-1:0]  r_wait;
  logic              r_MemTimeout;

  logic w_match_ex;
  logic w_match_mem;
  logic w_stall;
  logic w_freeze_req;
  logic w_rules;
  logic w_init_out;
  logic w_freeze_out;
  logic w_do_stall;
  logic w_do_taken;
  logic [CNT_W-1:0] w_wait_inc;

  // Register $0 is hardwired, so it can never carry a hazard.
  assign w_match_ex  = (i_EX_Rd != '0) &&
                       ((i_ID_UsesRs && (i_EX_Rd == i_ID_Rs)) || (i_ID_UsesRt && (i_EX_Rd == i_ID_Rt)));
  assign w_match_mem = (i_MEM_Rd != '0) &&
                       ((i_ID_UsesRs && (i_MEM_Rd == i_ID_Rs)) || (i_ID_UsesRt && (i_MEM_Rd == i_ID_Rt)));

  // Load-use, plus branch operands that are not yet forwardable into Decode.
  assign w_stall = (i_EX_MemRead && w_match_ex) ||
                   (i_ID_Branch && i_EX_RegWrite && w_match_ex) ||
                   (i_ID_Branch && i_MEM_MemRead && w_match_mem);

  assign w_freeze_req = i_MEM_Access && !i_MemReady;

  // Hazard/branch rules apply in RUN without a new wait, and on the cycle a frozen access completes.
  assign w_rules      = ((r_state == S_RUN) && !w_freeze_req) || ((r_state == S_FREEZE) && i_MemReady);
  assign w_init_out   = (r_state == S_INIT);
  assign w_freeze_out = !w_rules && !w_init_out;
  assign w_do_stall   = w_rules && w_stall;
  // A branch decision is untrusted while its operands are stalled, so a stall masks the flush.
  assign w_do_taken   = w_rules && !w_stall && i_ID_BranchTaken;

  assign o_PCWrite       = w_rules && !w_stall;
  assign o_IF_ID_Write   = w_rules && !w_stall;
  assign o_IF_ID_Flush   = w_init_out || w_do_taken;
  assign o_ID_EX_Bubble  = w_init_out || w_do_stall;
  assign o_EX_MEM_Write  = w_init_out || w_rules;
  assign o_MEM_WB_Bubble = w_init_out || w_freeze_out;
  assign o_MemTimeout    = r_MemTimeout;

  assign w_wait_inc = (r_wait == '1) ? r_wait : (r_wait + CNT_W'(1));

  // Control FSM: post-reset drain, run, memory freeze with watchdog, and terminal halt.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state      <= S_INIT;
      r_init_cnt   <= INIT_W'(INIT_CYCLES);
      r_wait       <= '0;
      r_MemTimeout <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_cnt <= r_init_cnt - INIT_W'(1);
          if (r_init_cnt <= INIT_W'(1)) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_freeze_req) begin
            r_state <= S_FREEZE;
            r_wait  <= CNT_W'(1);
          end
        end
        S_FREEZE: begin
          if (i_MemReady) begin
            r_state <= S_RUN;
            r_wait  <= '0;
          end else begin
            r_wait <= w_wait_inc;
            if (w_wait_inc >= CNT_W'(MEM_TIMEOUT)) begin
              r_state      <= S_HALT;
              r_MemTimeout <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic [CNT_W-1:0] r_freeze_cycles;

  // Saturating event counters for stall cycles, taken-branch flushes and frozen cycles.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
      r_freeze_cycles <= '0;
    end else begin
      if (w_do_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_do_taken && (r_flush_count != '1)) r_flush_count <= r_flush_count + CNT_W'(1);
      if ((r_state == S_FREEZE) && (r_freeze_cycles != '1)) r_freeze_cycles <= r_freeze_cycles + CNT_W'(1);
    end
  end

  assign o_StallCycles  = r_stall_cycles;
  assign o_FlushCount   = r_flush_count;
  assign o_FreezeCycles = r_freeze_cycles;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: vector table, directed multi-cycle sequences, random vs model.
module tb_pipeline_stall_controller;

  localparam int REG_W       = 5;
  localparam int INIT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 16;

  // Output bundle order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble, MemTimeout
  localparam logic [6:0] O_NORM  = 7'b1100100;
  localparam logic [6:0] O_STALL = 7'b0001100;
  localparam logic [6:0] O_TAKEN = 7'b1110100;
  localparam logic [6:0] O_FRZ   = 7'b0000010;
  localparam logic [6:0] O_HALT  = 7'b0000011;
  localparam logic [6:0] O_INIT  = 7'b0011110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_urs, id_urt, id_br, id_tk, ex_rw, ex_mr, mem_mr, mem_acc, mem_rdy;
  logic pcw, ifidw, flush, idexb, exmemw, memwbb, mto;
`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .REG_W(REG_W), .INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_Clk(clk), .i_Rst(rst_n),
    .i_ID_Rs(id_rs), .i_ID_Rt(id_rt), .i_ID_UsesRs(id_urs), .i_ID_UsesRt(id_urt),
    .i_ID_Branch(id_br), .i_ID_BranchTaken(id_tk),
    .i_EX_Rd(ex_rd), .i_EX_RegWrite(ex_rw), .i_EX_MemRead(ex_mr),
    .i_MEM_Rd(mem_rd), .i_MEM_MemRead(mem_mr), .i_MEM_Access(mem_acc), .i_MemReady(mem_rdy),
    .o_PCWrite(pcw), .o_IF_ID_Write(ifidw), .o_IF_ID_Flush(flush), .o_ID_EX_Bubble(idexb),
    .o_EX_MEM_Write(exmemw), .o_MEM_WB_Bubble(memwbb), .o_MemTimeout(mto)
`ifdef STALL_PERF_CNT_EN
    , .o_StallCycles(stall_cnt), .o_FlushCount(flush_cnt), .o_FreezeCycles(freeze_cnt)
`endif
  );

  typedef struct {
    int rs; int rt; bit urs; bit urt; bit br; bit tk;
    int exrd; bit exrw; bit exmr;
    int memrd; bit memmr; bit acc; bit rdy;
    logic [6:0] exp;
  } vec_t;

  function automatic vec_t mk(int rs, int rt, bit urs, bit urt, bit br, bit tk,
                              int exrd, bit exrw, bit exmr, int memrd, bit memmr,
                              bit acc, bit rdy, logic [6:0] e);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br; v.tk = tk;
    v.exrd = exrd; v.exrw = exrw; v.exmr = exmr;
    v.memrd = memrd; v.memmr = memmr; v.acc = acc; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  task automatic apply(vec_t v);
    id_rs = REG_W'(v.rs); id_rt = REG_W'(v.rt); id_urs = v.urs; id_urt = v.urt;
    id_br = v.br; id_tk = v.tk;
    ex_rd = REG_W'(v.exrd); ex_rw = v.exrw; ex_mr = v.exmr;
    mem_rd = REG_W'(v.memrd); mem_mr = v.memmr; mem_acc = v.acc; mem_rdy = v.rdy;
  endtask

  function automatic logic [6:0] outs();
    return {pcw, ifidw, flush, idexb, exmemw, memwbb, mto};
  endfunction

  task automatic chk(string nm, logic [6:0] e);
    logic [6:0] got;
    got = outs();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, got, e);
    end
  endtask

  // Inputs are changed 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic cyc_chk(string nm, logic [6:0] e);
    @(negedge clk);
    chk(nm, e);
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_age;      // cycles spent out of reset
  int m_wait;     // consecutive cycles the current memory access has been pending
  bit m_to;       // watchdog has fired

  function automatic bit m_match(logic [REG_W-1:0] r);
    return (r != 0) && ((id_urs && r == id_rs) || (id_urt && r == id_rt));
  endfunction

  function automatic logic [6:0] m_rules();
    bit hz;
    hz = (ex_mr && m_match(ex_rd)) || (id_br && ex_rw && m_match(ex_rd)) ||
         (id_br && mem_mr && m_match(mem_rd));
    if (hz) return O_STALL;
    if (id_tk) return O_TAKEN;
    return O_NORM;
  endfunction

  // Expected outputs for this cycle, then advance the model past the coming edge.
  task automatic m_step(output logic [6:0] e);
    bit pending;
    if (!rst_n) begin
      e = O_INIT; m_age = 0; m_wait = 0; m_to = 0;
    end else if (m_to) begin
      e = O_HALT;
    end else if (m_age < INIT_CYCLES) begin
      e = O_INIT; m_age++;
    end else begin
      pending = (m_wait > 0) ? !mem_rdy : (mem_acc && !mem_rdy);
      if (pending) begin
        e = O_FRZ;
        m_wait++;
        if (m_wait >= MEM_TIMEOUT) m_to = 1;
      end else begin
        m_wait = 0;
        e = m_rules();
      end
    end
  endtask

  vec_t tbl[16];
  vec_t z;

  initial begin
    logic [6:0] e;
    int ready_pct;
    z = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0, O_NORM);
    apply(z);

    tbl[0]  = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0, O_NORM);
    tbl[1]  = mk(8,0,1,0,0,0, 8,1,1, 0,0,0,0, O_STALL);   // lw $8 -> add uses $8
    tbl[2]  = mk(0,0,1,1,0,0, 0,1,1, 0,0,0,0, O_NORM);    // $0 never hazards
    tbl[3]  = mk(1,8,1,0,0,0, 8,1,1, 0,0,0,0, O_NORM);    // Rt matches but unused
    tbl[4]  = mk(1,8,1,1,0,0, 8,1,1, 0,0,0,0, O_STALL);   // Rt load-use
    tbl[5]  = mk(5,0,1,0,0,0, 5,1,0, 0,0,0,0, O_NORM);    // ALU result forwarded
    tbl[6]  = mk(5,0,1,0,1,0, 5,1,0, 0,0,0,0, O_STALL);   // branch needs EX ALU result
    tbl[7]  = mk(3,7,1,1,1,0, 0,0,0, 7,1,0,0, O_STALL);   // branch needs load in MEM
    tbl[8]  = mk(3,7,1,1,1,0, 0,0,0, 7,0,0,0, O_NORM);    // MEM non-load is forwardable
    tbl[9]  = mk(3,4,1,1,1,1, 6,1,0, 2,1,0,0, O_TAKEN);   // taken, no hazard
    tbl[10] = mk(5,4,1,1,1,1, 5,1,0, 0,0,0,0, O_STALL);   // taken suppressed by stall
    tbl[11] = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,1, O_NORM);    // MemReady without access
    tbl[12] = mk(0,0,0,0,0,0, 0,0,0, 0,0,1,1, O_NORM);    // single-cycle access
    tbl[13] = mk(8,0,1,0,0,0, 8,1,1, 0,0,1,0, O_FRZ);     // freeze beats load-use
    tbl[14] = mk(8,0,1,0,0,0, 8,1,1, 0,0,1,1, O_STALL);   // release -> load-use stall
    tbl[15] = mk(8,0,1,0,0,0, 0,0,0, 8,1,0,0, O_NORM);    // non-branch with MEM load

    // Reset state and drain sequence
    @(negedge clk);
    chk("reset_outs", O_INIT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc_chk("init_c1", O_INIT);
    cyc_chk("init_c2", O_INIT);
    cyc_chk("init_run", O_NORM);

    // Vector table (RUN state)
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      cyc_chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Load feeding a taken branch: two stalls, then exactly one flush
    apply(mk(9,0,1,0,1,1, 9,1,1, 0,0,0,0, O_STALL));
    cyc_chk("lwbr_stall1", O_STALL);
    apply(mk(9,0,1,0,1,1, 0,0,0, 9,1,0,0, O_STALL));
    cyc_chk("lwbr_stall2", O_STALL);
    apply(mk(9,0,1,0,1,1, 0,0,0, 0,0,0,0, O_TAKEN));
    cyc_chk("lwbr_flush", O_TAKEN);
    apply(z);
    cyc_chk("lwbr_after", O_NORM);

    // Three-cycle memory wait, then release
    apply(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,0, O_FRZ));
    cyc_chk("frz_c1", O_FRZ);
    cyc_chk("frz_c2", O_FRZ);
    cyc_chk("frz_c3", O_FRZ);
    mem_rdy = 1'b1;
    cyc_chk("frz_release", O_NORM);
    apply(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,0, O_FRZ));
    cyc_chk("frz_back_in_run", O_FRZ);
    mem_rdy = 1'b1;
    cyc_chk("frz_release2", O_NORM);

    // Watchdog: 16 pending cycles, then sticky halt
    apply(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,0, O_FRZ));
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      @(negedge clk);
      if (i == 1 || i == MEM_TIMEOUT) chk($sformatf("wd_wait%0d", i), O_FRZ);
      @(posedge clk); #1;
    end
    cyc_chk("wd_halt", O_HALT);
    mem_rdy = 1'b1;
    cyc_chk("wd_halt_ignores_ready", O_HALT);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wd_reset_async", O_INIT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(z);
    cyc_chk("wd_reinit1", O_INIT);
    cyc_chk("wd_reinit2", O_INIT);
    cyc_chk("wd_reinit_run", O_NORM);

    // Randomized run against the model, starting from a fresh reset
    rst_n = 1'b0;
    ready_pct = 75;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) ready_pct = ((c / 250) % 3 == 2) ? 4 : 75;
      if (c > 2) begin
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      end
      id_rs  = REG_W'($urandom_range(0, 3));
      id_rt  = REG_W'($urandom_range(0, 3));
      ex_rd  = REG_W'($urandom_range(0, 3));
      mem_rd = REG_W'($urandom_range(0, 3));
      id_urs = 1'($urandom_range(0, 1));
      id_urt = 1'($urandom_range(0, 1));
      id_br  = ($urandom_range(0, 3) == 0);
      id_tk  = id_br && ($urandom_range(0, 1) == 1);
      ex_rw  = 1'($urandom_range(0, 1));
      ex_mr  = ex_rw && ($urandom_range(0, 2) == 0);
      mem_mr = ($urandom_range(0, 3) == 0);
      mem_acc = ($urandom_range(0, 2) == 0);
      mem_rdy = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      m_step(e);
      chk($sformatf("rand%0d", c), e);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
